// File: rtl/full_sub.sv
// rtl/full_sub.sv - WIDTH-bit ripple-borrow full subtractor with registered result and valid.
// One combinational borrow chain feeds the output registers; latency is one clock.
module full_sub #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] diff,
  output logic             borr,
  output logic             out_valid
);

  logic [WIDTH-1:0] diff_next;
  logic             borr_next;

  // Borrow ripples LSB to MSB; a single variable keeps the chain free of feedback on a vector.
  always_comb begin
    logic chain;
    diff_next = '0;
    chain     = bin;
    for (int i = 0; i < WIDTH; i++) begin
      diff_next[i] = a[i] ^ b[i] ^ chain;
      chain        = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain);
    end
    borr_next = chain;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff      <= '0;
      borr      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diff <= diff_next;
        borr <= borr_next;
      end
    end
  end

endmodule

// File: tb/tb_full_sub.sv
// tb/tb_full_sub.sv - randomized and directed bench for full_sub at WIDTH 1, 8 and 16.
module tb_full_sub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        bin = 1'b0;
  logic        in_valid = 1'b0;

  logic [0:0]  d1;
  logic        br1, ov1;
  logic [7:0]  d8;
  logic        br8, ov8;
  logic [15:0] d16;
  logic        br16, ov16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  full_sub #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a16[0:0]), .b(b16[0:0]), .bin(bin),
    .in_valid(in_valid), .diff(d1), .borr(br1), .out_valid(ov1)
  );
  full_sub #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a16[7:0]), .b(b16[7:0]), .bin(bin),
    .in_valid(in_valid), .diff(d8), .borr(br8), .out_valid(ov8)
  );
  full_sub #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .bin(bin),
    .in_valid(in_valid), .diff(d16), .borr(br16), .out_valid(ov16)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: {borr,diff} is the wrapped (W+1)-bit value of a - b - bin, held while in_valid is low.
  logic [16:0] m16;
  logic [8:0]  m8;
  logic [1:0]  m1;
  logic        mv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m16 <= '0; m8 <= '0; m1 <= '0; mv <= 1'b0;
    end else begin
      mv <= in_valid;
      if (in_valid) begin
        m16 <= 17'(int'(a16) - int'(b16) - int'(bin));
        m8  <= 9'(int'(a16[7:0]) - int'(b16[7:0]) - int'(bin));
        m1  <= 2'(int'(a16[0]) - int'(b16[0]) - int'(bin));
      end
    end
  end

  always @(negedge clk) begin
    check("w1_diff", 64'(d1), 64'(m1[0]));
    check("w1_borr", 64'(br1), 64'(m1[1]));
    check("w1_valid", 64'(ov1), 64'(mv));
    check("w8_diff", 64'(d8), 64'(m8[7:0]));
    check("w8_borr", 64'(br8), 64'(m8[8]));
    check("w8_valid", 64'(ov8), 64'(mv));
    check("w16_diff", 64'(d16), 64'(m16[15:0]));
    check("w16_borr", 64'(br16), 64'(m16[16]));
    check("w16_valid", 64'(ov16), 64'(mv));
  end

  task automatic drive(input logic [15:0] na, input logic [15:0] nb, input logic nbin, input logic nv);
    @(negedge clk);
    #1;
    a16 = na; b16 = nb; bin = nbin; in_valid = nv;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_d16"}, 64'(d16), 64'h0);
    check({tag, "_b16"}, 64'(br16), 64'h0);
    check({tag, "_v16"}, 64'(ov16), 64'h0);
    check({tag, "_d8"}, 64'(d8), 64'h0);
    check({tag, "_d1"}, 64'(d1), 64'h0);
  endtask

  logic [1:0] tt [8];

  initial begin
    tt = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

    // reset state, with operands offered while held in reset
    a16 = 16'h1234; b16 = 16'h0001; bin = 1'b1; in_valid = 1'b1;
    after_edge();
    check_all_zero("reset");
    after_edge();
    check_all_zero("reset2");
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;

    // WIDTH=1 truth table, upper bits randomized
    for (int i = 0; i < 8; i++) begin
      drive({$urandom_range(0, 16'h7fff) % 16'h8000, 1'b0} | 16'(i[2]),
            {$urandom_range(0, 16'h7fff) % 16'h8000, 1'b0} | 16'(i[1]), i[0], 1'b1);
      after_edge();
      check($sformatf("tt%0d_diff", i), 64'(d1), 64'(tt[i][1]));
      check($sformatf("tt%0d_borr", i), 64'(br1), 64'(tt[i][0]));
      check($sformatf("tt%0d_valid", i), 64'(ov1), 64'h1);
    end

    // WIDTH=8 directed
    drive(16'h0000, 16'h0001, 1'b0, 1'b1);
    after_edge();
    check("w8a_diff", 64'(d8), 64'hff);
    check("w8a_borr", 64'(br8), 64'h1);
    drive(16'h0080, 16'h0001, 1'b1, 1'b1);
    after_edge();
    check("w8b_diff", 64'(d8), 64'h7e);
    check("w8b_borr", 64'(br8), 64'h0);

    // boundaries at WIDTH=16
    drive(16'h1234, 16'h1234, 1'b0, 1'b1);
    after_edge();
    check("eq_diff", 64'(d16), 64'h0);
    check("eq_borr", 64'(br16), 64'h0);
    drive(16'h0000, 16'h0000, 1'b1, 1'b1);
    after_edge();
    check("zero_bin_diff", 64'(d16), 64'hffff);
    check("zero_bin_borr", 64'(br16), 64'h1);
    drive(16'hffff, 16'hffff, 1'b1, 1'b1);
    after_edge();
    check("ones_bin_diff", 64'(d16), 64'hffff);
    check("ones_bin_borr", 64'(br16), 64'h1);

    // hold
    drive(16'h0001, 16'h0000, 1'b0, 1'b1);
    after_edge();
    check("hold_load_diff", 64'(d16), 64'h1);
    for (int i = 0; i < 3; i++) begin
      drive(16'h0000, 16'h0001, 1'b1, 1'b0);
      after_edge();
      check($sformatf("hold%0d_diff", i), 64'(d16), 64'h1);
      check($sformatf("hold%0d_borr", i), 64'(br16), 64'h0);
      check($sformatf("hold%0d_valid", i), 64'(ov16), 64'h0);
    end

    // reset between edges during back-to-back traffic
    for (int i = 0; i < 4; i++) drive(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    after_edge();
    check_all_zero("midrst_edge");
    drive(16'h0005, 16'h0007, 1'b0, 1'b1);
    #2 rst_n = 1'b1;
    after_edge();
    check("resume_diff", 64'(d16), 64'hfffe);
    check("resume_borr", 64'(br16), 64'h1);
    check("resume_valid", 64'(ov16), 64'h1);

    // randomized traffic; the compare process checks every cycle
    for (int i = 0; i < 1000; i++)
      drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    after_edge();
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
